esm_config_decoder: RTL

//  Parses the ESM control stream (magic, seq num, header, payload) arriving on a single-clock AXI-stream
//  and routes payload words to the addressed module (dwell controller, channelizers, PDW encoder).

---
 rtl/esm_pkg.sv | 46 ++++
 rtl/esm_config_global_regs.sv | 39 +++
 rtl/esm_config_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/esm_pkg.sv
// Shared ESM control-stream constants, routed-word payload type and decoder state encoding.
package esm_pkg;

  localparam logic [31:0] esm_control_magic_num = 32'hE5A1_C0DE;

  localparam logic [7:0] esm_module_id_global      = 8'h00;
  localparam logic [7:0] esm_module_id_dwell       = 8'h01;
  localparam logic [7:0] esm_module_id_channelizer = 8'h02;
  localparam logic [7:0] esm_module_id_pdw         = 8'h03;

  localparam logic [7:0] esm_control_message_type_enables     = 8'h00;
  localparam logic [7:0] esm_control_message_type_dwell_entry = 8'h01;
  localparam logic [7:0] esm_control_message_type_channel_cfg = 8'h02;
  localparam logic [7:0] esm_control_message_type_pdw_cfg     = 8'h03;

  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
    logic [7:0]  module_id;
    logic [7:0]  message_type;
    logic [7:0]  word_index;
    logic [31:0] data;
  } esm_config_data_t;

  // Fields of global payload word 0 that drive the enable outputs.
  typedef struct packed {
    logic       rst_request;
    logic [1:0] pdw;
    logic [1:0] channelizer;
    logic       status;
  } esm_global_enables_t;

  typedef enum logic [2:0] {
    S_MAGIC,
    S_SEQ,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } esm_config_decoder_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/esm_config_global_regs.sv
// Decodes global (module 0, type 0, word 0) payloads into the enable bits and a reset-request pulse.
module esm_config_global_regs
  import esm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic [7:0]          module_id,
  input  logic [7:0]          message_type,
  input  logic [7:0]          word_index,
  input  esm_global_enables_t word_bits,
  output logic                enable_status,
  output logic [1:0]          enable_channelizer,
  output logic [1:0]          enable_pdw,
  output logic                rst_request
);

  logic hit_c;

  assign hit_c = cfg_valid && (module_id == esm_module_id_global) &&
                 (message_type == esm_control_message_type_enables) && (word_index == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_status      <= 1'b0;
      enable_channelizer <= 2'd0;
      enable_pdw         <= 2'd0;
      rst_request        <= 1'b0;
    end else begin
      rst_request <= hit_c && word_bits.rst_request;
      if (hit_c) begin
        enable_status      <= word_bits.status;
        enable_channelizer <= word_bits.channelizer;
        enable_pdw         <= word_bits.pdw;
      end
    end
  end

endmodule

// File: rtl/esm_config_decoder.sv
// ESM control-stream parser: magic/seq/header checks, payload routing onto Cfg_*, error counters.
// Optional ESM_CONFIG_DECODER_LENGTH_CHECK_EN caps payload length at MAX_MSG_WORDS (adds one word of hold latency).
module esm_config_decoder
  import esm_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32
`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
  , parameter int unsigned MAX_MSG_WORDS = 64
`endif
) (
  input  logic                      Clk,
  input  logic                      Rst,
  output logic                      S_axis_ready,
  input  logic                      S_axis_valid,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic                      S_axis_last,
  output logic                      Cfg_valid,
  output logic                      Cfg_first,
  output logic                      Cfg_last,
  output logic [7:0]                Cfg_module_id,
  output logic [7:0]                Cfg_message_type,
  output logic [7:0]                Cfg_word_index,
  output logic [AXI_DATA_WIDTH-1:0] Cfg_data,
  output logic                      Enable_status,
  output logic [1:0]                Enable_channelizer,
  output logic [1:0]                Enable_pdw,
  output logic                      Rst_request,
  output logic [15:0]               Err_magic_count,
  output logic [15:0]               Err_seq_count,
`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
  output logic [15:0]               Err_length_count,
`endif
  output logic [15:0]               Err_short_count
);

  localparam int unsigned CNT_W = 16;

  esm_config_decoder_state_t state;
  logic                      ready_q;
  logic                      rst_d;
  logic [AXI_DATA_WIDTH-1:0] expected_seq;
  logic [7:0]                module_id;
  logic [7:0]                message_type;
  logic [7:0]                word_idx;
  logic [CNT_W-1:0]          err_magic;
  logic [CNT_W-1:0]          err_seq;
  logic [CNT_W-1:0]          err_short;
  logic                      accept_c;
  esm_config_data_t          beat_c;
  esm_config_data_t          cfg_d;
  esm_config_data_t          cfg_q;
  esm_global_enables_t       enables_c;

  assign accept_c = S_axis_valid && ready_q;

  // Payload beat as it would appear on Cfg_* one cycle later.
  always_comb begin
    beat_c = '0;
    if (accept_c && (state == S_PAYLOAD)) begin
      beat_c.valid        = 1'b1;
      beat_c.first        = (word_idx == 8'd0);
      beat_c.last         = S_axis_last;
      beat_c.module_id    = module_id;
      beat_c.message_type = message_type;
      beat_c.word_index   = word_idx;
      beat_c.data         = 32'(S_axis_data);
    end
  end

`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
  esm_config_data_t pend_q;
  esm_config_data_t pend_d;
  logic             len_trip_c;
  logic [CNT_W-1:0] err_length;

  // Each word waits until the next one proves whether it must be marked last.
  always_comb begin
    cfg_d      = '0;
    pend_d     = pend_q;
    len_trip_c = 1'b0;
    if (beat_c.valid) begin
      cfg_d = pend_q;
      if ((32'(beat_c.word_index) == MAX_MSG_WORDS) && !beat_c.last) begin
        len_trip_c = 1'b1;
        cfg_d.last = pend_q.valid;
        pend_d     = '0;
      end else begin
        pend_d = beat_c;
      end
    end else if (pend_q.valid && pend_q.last) begin
      cfg_d  = pend_q;
      pend_d = '0;
    end
  end

  assign Err_length_count = err_length;
`else
  assign cfg_d = beat_c;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= S_MAGIC;
      ready_q      <= 1'b0;
      rst_d        <= 1'b1;
      expected_seq <= '0;
      module_id    <= '0;
      message_type <= '0;
      word_idx     <= '0;
      err_magic    <= '0;
      err_seq      <= '0;
      err_short    <= '0;
      cfg_q        <= '0;
`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
      pend_q       <= '0;
      err_length   <= '0;
`endif
    end else begin
      rst_d   <= 1'b0;
      ready_q <= !rst_d;
      cfg_q   <= cfg_d;
`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
      pend_q  <= pend_d;
`endif
      if (accept_c) begin
        case (state)
          S_MAGIC: begin
            if (S_axis_data == esm_control_magic_num) begin
              if (S_axis_last) err_short <= sat_inc16(err_short);
              else             state     <= S_SEQ;
            end else begin
              err_magic <= sat_inc16(err_magic);
              if (!S_axis_last) state <= S_DROP;
            end
          end
          S_SEQ: begin
            expected_seq <= S_axis_data + AXI_DATA_WIDTH'(1);
            // A message ending here is short; the sequence check is skipped for it.
            if (S_axis_last) begin
              err_short <= sat_inc16(err_short);
              state     <= S_MAGIC;
            end else begin
              if (S_axis_data != expected_seq) err_seq <= sat_inc16(err_seq);
              state <= S_HEADER;
            end
          end
          S_HEADER: begin
            module_id    <= S_axis_data[31:24];
            message_type <= S_axis_data[23:16];
            word_idx     <= 8'd0;
            state        <= S_axis_last ? S_MAGIC : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            if (word_idx != 8'hFF) word_idx <= word_idx + 8'd1;
            if (S_axis_last)       state    <= S_MAGIC;
`ifdef ESM_CONFIG_DECODER_LENGTH_CHECK_EN
            if (len_trip_c) begin
              err_length <= sat_inc16(err_length);
              state      <= S_DROP;
            end
`endif
          end
          S_DROP: begin
            if (S_axis_last) state <= S_MAGIC;
          end
          default: state <= S_MAGIC;
        endcase
      end
    end
  end

  assign enables_c = {cfg_d.data[24], cfg_d.data[17:16], cfg_d.data[9:8], cfg_d.data[0]};

  esm_config_global_regs u_global_regs (
    .clk                (Clk),
    .rst                (Rst),
    .cfg_valid          (cfg_d.valid),
    .module_id          (cfg_d.module_id),
    .message_type       (cfg_d.message_type),
    .word_index         (cfg_d.word_index),
    .word_bits          (enables_c),
    .enable_status      (Enable_status),
    .enable_channelizer (Enable_channelizer),
    .enable_pdw         (Enable_pdw),
    .rst_request        (Rst_request)
  );

  assign S_axis_ready     = ready_q;
  assign Cfg_valid        = cfg_q.valid;
  assign Cfg_first        = cfg_q.first;
  assign Cfg_last         = cfg_q.last;
  assign Cfg_module_id    = cfg_q.module_id;
  assign Cfg_message_type = cfg_q.message_type;
  assign Cfg_word_index   = cfg_q.word_index;
  assign Cfg_data         = AXI_DATA_WIDTH'(cfg_q.data);
  assign Err_magic_count  = err_magic;
  assign Err_seq_count    = err_seq;
  assign Err_short_count  = err_short;

endmodule
